// File: rtl/reg_wb_port.sv
// reg_wb_port -- writer side of the register-file write port.
//
// Merges single-cycle pipeline results (port A) with long-latency results
// (port B, buffered in a FIFO) into one registered register-file write per
// cycle. A pending scoreboard tracks registers that still have an
// outstanding long-latency write so decode can stall on them.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   a_valid/a_rd/a_data pipeline writeback request (no ready; see a_stall)
//   a_stall             registered; 1 = A not served this cycle
//   b_valid/b_rd/b_data long-latency result; b_ready = FIFO not full
//   iss_valid/iss_rd    long-latency op issued, marks iss_rd pending
//   rs1/rs2             decode sources; busy_rs1/busy_rs2 = pending bit
//   Wr_en/Wr_rd/Wr_data registered register-file write
module reg_wb_port #(
   parameter int n          = 32,
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         a_valid,
   input  logic [4:0]   a_rd,
   input  logic [n-1:0] a_data,
   output logic         a_stall,
   input  logic         b_valid,
   output logic         b_ready,
   input  logic [4:0]   b_rd,
   input  logic [n-1:0] b_data,
   input  logic         iss_valid,
   input  logic [4:0]   iss_rd,
   input  logic [4:0]   rs1,
   input  logic [4:0]   rs2,
   output logic         busy_rs1,
   output logic         busy_rs2,
   output logic         Wr_en,
   output logic [4:0]   Wr_rd,
   output logic [n-1:0] Wr_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_MAX) + 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW:0]    wr_ptr, rd_ptr;
   logic [4:0]     fifo_rd   [DEPTH];
   logic [n-1:0]   fifo_data [DEPTH];
   logic [31:0]    pending, pending_nxt;
   logic [CW-1:0]  starve_cnt;

   logic           empty, full, push, pop, serve_a;
   logic [4:0]     head_rd;
   logic [n-1:0]   head_data;
   logic           wr_go;
   logic [4:0]     wr_rd_sel;
   logic [n-1:0]   wr_data_sel;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign b_ready   = !full;
   assign push      = b_valid && !full;
   // a_stall forces a B pop and hides a_valid for that cycle.
   assign serve_a   = !a_stall && a_valid;
   assign pop       = !serve_a && !empty;
   assign head_rd   = fifo_rd[rd_ptr[PW-1:0]];
   assign head_data = fifo_data[rd_ptr[PW-1:0]];

   assign busy_rs1  = pending[rs1];
   assign busy_rs2  = pending[rs2];

   always_comb begin
      wr_go       = 1'b0;
      wr_rd_sel   = a_rd;
      wr_data_sel = a_data;
      if (serve_a) begin
         wr_go = (a_rd != 5'd0);
      end else if (pop) begin
         wr_go       = (head_rd != 5'd0);
         wr_rd_sel   = head_rd;
         wr_data_sel = head_data;
      end
   end

   // Clear on B write, then set on issue so a same-cycle set wins.
   always_comb begin
      pending_nxt = pending;
      if (pop)
         pending_nxt[head_rd] = 1'b0;
      if (iss_valid && (iss_rd != 5'd0))
         pending_nxt[iss_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr[PW-1:0]]   <= b_rd;
         fifo_data[wr_ptr[PW-1:0]] <= b_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pending    <= '0;
         starve_cnt <= '0;
         a_stall    <= 1'b0;
         Wr_en      <= 1'b0;
         Wr_rd      <= '0;
         Wr_data    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         pending <= pending_nxt;

         Wr_en <= wr_go;
         if (wr_go) begin
            Wr_rd   <= wr_rd_sel;
            Wr_data <= wr_data_sel;
         end

         // Count A wins over a waiting B entry; the STARVE_MAX-th such win
         // raises a_stall for exactly one cycle, which forces one B pop.
         a_stall <= 1'b0;
         if (pop || empty) begin
            starve_cnt <= '0;
         end else if (serve_a) begin
            if (starve_cnt == CW'(STARVE_MAX - 1)) begin
               a_stall    <= 1'b1;
               starve_cnt <= '0;
            end else begin
               starve_cnt <= starve_cnt + 1'b1;
            end
         end
      end
   end

endmodule
